// File: rtl/cordic_vec.sv
// -----------------------------------------------------------------------------
// cordic_vec -- iterative vectoring-mode CORDIC (cartesian -> polar)
//
// Converts one complex sample (x, y) in signed 20.44 fixed point into its
// magnitude sqrt(x^2+y^2) and phase atan2(y, x) in radians, also 20.44.
// One sample is in flight at a time; both sides use a valid/ready handshake.
//
// Flow: IDLE -> PRE (quadrant fold) -> CALC (ITER micro-rotations)
//       -> GAIN (1/K scaling) -> OUT (hold until out_ready).
//
// Parameters:
//   ITER  number of micro-rotations, 1..44
//   DW    data width; fixed point is always 20.44 (DW-44 integer bits)
//
// Ports:
//   clk        clock, rising edge
//   rstn       synchronous active-low reset; aborts any sample in flight
//   in_valid   x_i / y_i valid
//   in_ready   block can accept a sample (registered)
//   x_i, y_i   real / imaginary input, signed 20.44
//   out_valid  mag_o / phase_o valid (registered)
//   out_ready  downstream accepts the result
//   mag_o      magnitude, signed 20.44, never negative
//   phase_o    phase in radians, signed 20.44
//
// Build option:
//   CORDIC_VEC_ROUND_EN  when defined, the final 1/K multiply rounds half up
//                        instead of truncating. Timing is identical.
// -----------------------------------------------------------------------------
module cordic_vec #(
  parameter int ITER = 44,
  parameter int DW   = 64
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] x_i,
  input  logic [DW-1:0] y_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] mag_o,
  output logic [DW-1:0] phase_o
);

  localparam int IW = 6;

  // pi and 1/K (K = CORDIC gain for many iterations) in 20.44
  localparam logic [DW-1:0] PI   = DW'(64'h0000_3243_F6A8_885A);
  localparam logic [DW-1:0] KINV = DW'(64'h0000_09B7_4EDA_8436);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_CALC = 3'd2,
    S_GAIN = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // atan(2^-idx) scaled by 2^44, rounded. From idx 15 on the cubic term is
  // below half an LSB, so the entry is simply 2^(44-idx).
  function automatic logic [DW-1:0] atan_lut(input logic [IW-1:0] idx);
    case (idx)
      6'd0:    atan_lut = DW'(64'h0000_0C90_FDAA_2217);
      6'd1:    atan_lut = DW'(64'h0000_076B_19C1_586F);
      6'd2:    atan_lut = DW'(64'd4309710218640);
      6'd3:    atan_lut = DW'(64'd2187676199619);
      6'd4:    atan_lut = DW'(64'd1098083318120);
      6'd5:    atan_lut = DW'(64'd549576961702);
      6'd6:    atan_lut = DW'(64'd274855540599);
      6'd7:    atan_lut = DW'(64'd137436157372);
      6'd8:    atan_lut = DW'(64'd68719127214);
      6'd9:    atan_lut = DW'(64'd34359694677);
      6'd10:   atan_lut = DW'(64'd17179863723);
      6'd11:   atan_lut = DW'(64'd8589933909);
      6'd12:   atan_lut = DW'(64'd4294967211);
      6'd13:   atan_lut = DW'(64'd2147483637);
      6'd14:   atan_lut = DW'(64'd1073741823);
      default: atan_lut = DW'(64'd1) << (6'd44 - idx);
    endcase
  endfunction

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  in_ready_nxt_s;
  logic                  out_valid_nxt_s;
  logic                  accept_s;

  logic signed [DW-1:0]  x_r;
  logic signed [DW-1:0]  y_r;
  logic signed [DW-1:0]  z_r;
  logic [IW-1:0]         i_r;
  logic                  zflag_r;

  logic signed [DW-1:0]  x_sh_s;
  logic signed [DW-1:0]  y_sh_s;
  logic signed [DW-1:0]  atan_s;
  logic [2*DW-1:0]       prod_s;
  logic [2*DW-1:0]       prod_rnd_s;

  assign accept_s = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nxt_s = S_PRE;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PRE:  state_nxt_s = S_CALC;
      S_CALC: begin
        if (i_r == IW'(ITER - 1)) begin
          state_nxt_s = S_GAIN;
        end else begin
          state_nxt_s = S_CALC;
        end
      end
      S_GAIN: state_nxt_s = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_OUT;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Handshake outputs, decoded from the next state so they can be registered
  always_comb begin
    in_ready_nxt_s  = (state_nxt_s == S_IDLE);
    out_valid_nxt_s = (state_nxt_s == S_OUT);
  end

  // Registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= in_ready_nxt_s;
      out_valid <= out_valid_nxt_s;
    end
  end

  // Micro-rotation operands: shifts always use the pre-update x and y
  always_comb begin
    x_sh_s = x_r >>> i_r;
    y_sh_s = y_r >>> i_r;
    atan_s = atan_lut(i_r);
  end

  // Gain correction product; x is sign-extended, KINV is positive
  always_comb begin
    prod_s = {{DW{x_r[DW-1]}}, x_r} * {{DW{1'b0}}, KINV};
`ifdef CORDIC_VEC_ROUND_EN
    prod_rnd_s = prod_s + {{(2*DW-44){1'b0}}, 1'b1, 43'd0};
`else
    prod_rnd_s = prod_s;
`endif
  end

  // Datapath: load, fold, rotate, scale
  always_ff @(posedge clk) begin
    if (!rstn) begin
      x_r     <= {DW{1'b0}};
      y_r     <= {DW{1'b0}};
      z_r     <= {DW{1'b0}};
      i_r     <= {IW{1'b0}};
      zflag_r <= 1'b0;
      mag_o   <= {DW{1'b0}};
      phase_o <= {DW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            x_r     <= x_i;
            y_r     <= y_i;
            z_r     <= {DW{1'b0}};
            i_r     <= {IW{1'b0}};
            zflag_r <= (x_i == {DW{1'b0}}) && (y_i == {DW{1'b0}});
          end
        end
        S_PRE: begin
          // Left half-plane: rotate by pi so CORDIC only sees |angle| <= pi/2.
          // The sign of the original y picks +pi or -pi so y=0 lands on +pi.
          if (x_r[DW-1]) begin
            x_r <= -x_r;
            y_r <= -y_r;
            if (y_r[DW-1]) begin
              z_r <= -$signed(PI);
            end else begin
              z_r <= $signed(PI);
            end
          end
        end
        S_CALC: begin
          if (!y_r[DW-1]) begin
            x_r <= x_r + y_sh_s;
            y_r <= y_r - x_sh_s;
            z_r <= z_r + atan_s;
          end else begin
            x_r <= x_r - y_sh_s;
            y_r <= y_r + x_sh_s;
            z_r <= z_r - atan_s;
          end
          i_r <= i_r + 6'd1;
        end
        S_GAIN: begin
          if (zflag_r) begin
            mag_o   <= {DW{1'b0}};
            phase_o <= {DW{1'b0}};
          end else begin
            mag_o   <= prod_rnd_s[DW+43:44];
            phase_o <= z_r;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
